// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: holds operands for SETTLE cycles, captures z/zero, returns them over valid/ready.
// Optional performance counters perf_ops/perf_zero are built when ALU_ISSUE_PERF_EN is defined.
module alu_issue_ctrl #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_zero,
  output logic             rsp_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_zero
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } state_t;

  // SETTLE is limited to 1..15 so the settle count fits in four bits.
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;

  function automatic logic op_illegal(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_illegal = 1'b0;
      default:                                op_illegal = 1'b1;
    endcase
  endfunction

  // In RESP a new command may only enter on the edge that retires the response.
  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_RESP: cmd_ready = rsp_ready;
      default: cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= 3'b000;
      rsp_valid   <= 1'b0;
      rsp_z       <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a  <= cmd_a;
            alu_b  <= cmd_b;
            alu_op <= cmd_op;
            cnt    <= SETTLE_M1;
            state  <= ST_SETTLE;
          end
        end
        // Operands frozen on the ALU inputs while the carry chain settles.
        ST_SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_z       <= alu_z;
            rsp_zero    <= alu_zero;
            rsp_illegal <= op_illegal(alu_op);
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (cmd_valid) begin
              alu_a  <= cmd_a;
              alu_b  <= cmd_b;
              alu_op <= cmd_op;
              cnt    <= SETTLE_M1;
              state  <= ST_SETTLE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops  <= 32'd0;
      perf_zero <= 32'd0;
    end else if (rsp_valid && rsp_ready) begin
      perf_ops <= perf_ops + 32'd1;
      if (rsp_zero) perf_zero <= perf_zero + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached; checks counters when ALU_ISSUE_PERF_EN is defined.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_z;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_z;
  logic        rsp_zero;
  logic        rsp_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_zero;
`endif

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .SETTLE(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_z       (alu_z),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_z       (rsp_z),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_zero   (perf_zero)
`endif
  );

  // Reference ALU; op 011 returns a marker value so its passthrough is visible.
  always_comb begin
    case (alu_op)
      3'b000:  alu_z = alu_a & alu_b;
      3'b001:  alu_z = alu_a | alu_b;
      3'b010:  alu_z = alu_a + alu_b;
      3'b110:  alu_z = alu_a - alu_b;
      3'b111:  alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_z = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_z == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with rsp_ready=1 and check the response timing and contents.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ez, input logic ezero,
                        input logic eill);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b1;
    chk({tag, "_rdy"}, {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_op_issued"}, {29'd0, alu_op}, {29'd0, op});
    chk({tag, "_busy"}, {31'd0, cmd_ready}, 32'd0);
    tick();
    chk({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_z"}, rsp_z, ez);
    chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, ezero});
    chk({tag, "_ill"}, {31'd0, rsp_illegal}, {31'd0, eill});
    tick();
    chk({tag, "_retired"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_idle_rdy"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = 3'b000; rsp_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_z", rsp_z, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    run_op("add", 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    run_op("sub", 3'b110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    run_op("slt", 3'b111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);

    // Backpressure: response must hold and new commands must be ignored.
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = 32'd100; cmd_b = 32'd23;
    tick();
    cmd_a = 32'd55; cmd_b = 32'd66; cmd_op = 3'b000;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_z", rsp_z, 32'd123);
      chk("bp_zero", {31'd0, rsp_zero}, 32'd0);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    chk("bp_alu_a_frozen", alu_a, 32'd100);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {31'd0, cmd_ready}, 32'd1);
    tick();
    chk("bp_retired", {31'd0, rsp_valid}, 32'd0);

    // Back-to-back: second command accepted on the edge the first retires.
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 32'hF0; cmd_b = 32'h3C; rsp_ready = 1'b1;
    tick();
    tick();
    chk("b2b_first_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("b2b_first_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_first_z", rsp_z, 32'h30);
    cmd_op = 3'b001; cmd_a = 32'hF0; cmd_b = 32'h0F;
    #1;
    chk("b2b_rdy_in_resp", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_retire", {31'd0, rsp_valid}, 32'd0);
    chk("b2b_second_op", {29'd0, alu_op}, 32'd1);
    chk("b2b_second_b", alu_b, 32'h0F);
    tick();
    chk("b2b_second_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("b2b_second_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_second_z", rsp_z, 32'hFF);
    tick();
    chk("b2b_done", {31'd0, rsp_valid}, 32'd0);

    run_op("illegal", 3'b011, 32'd3, 32'd1, 32'hDEADBEEF, 1'b0, 1'b1);

`ifdef ALU_ISSUE_PERF_EN
    chk("perf_ops", perf_ops, 32'd7);
    chk("perf_zero", perf_zero, 32'd1);
`endif

    // Reset during SETTLE discards the operation.
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = 32'd1; cmd_b = 32'd1; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("mid_busy", {31'd0, cmd_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rdy", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    #3 rst = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_rst_rdy", {31'd0, cmd_ready}, 32'd1);
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_ops_rst", perf_ops, 32'd0);
    chk("perf_zero_rst", perf_zero, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
